// File: rtl/component_pkg.sv
// component_pkg: shared state encoding for the component library
package component_pkg;
  typedef enum logic [1:0] {
    SKB_EMPTY = 2'd0,
    SKB_BUSY  = 2'd1,
    SKB_FULL  = 2'd2
  } skb_state_t;
endpackage

// File: rtl/component_skid_buffer.sv
// component_skid_buffer: two-entry registered valid/ready stage with a flopped in_ready
module component_skid_buffer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [1:0]       occupancy
);
  import component_pkg::*;
  skb_state_t state, nxt;
  logic [WIDTH-1:0] skid;
  logic accept, xfer, main_en, skid_en;
  assign accept    = in_valid && in_ready;
  assign xfer      = out_valid && out_ready;
  assign out_valid = state != SKB_EMPTY;
  assign occupancy = state == SKB_FULL ? 2'd2 : state == SKB_BUSY ? 2'd1 : 2'd0;
  // next state and register enables; the unused encoding falls back to EMPTY
  always_comb begin
    nxt = state == SKB_EMPTY ? (accept ? SKB_BUSY : SKB_EMPTY) :
          state == SKB_BUSY  ? (accept && !xfer ? SKB_FULL : !accept && xfer ? SKB_EMPTY : SKB_BUSY) :
          state == SKB_FULL  ? (xfer ? SKB_BUSY : SKB_FULL) : SKB_EMPTY;
    main_en = (state == SKB_EMPTY && accept) || (state == SKB_BUSY && accept && xfer) ||
              (state == SKB_FULL && xfer);
    skid_en = state == SKB_BUSY && accept && !xfer;
  end
  // state and in_ready flop; in_ready looks ahead so out_ready never reaches it combinationally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= SKB_EMPTY;
      in_ready <= 1'b0;
    end else begin
      state    <= nxt;
      in_ready <= nxt != SKB_FULL;
    end
  end
  // main register drives out_data; refilled from skid when draining FULL
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) out_data <= '0;
    else if (main_en) out_data <= state == SKB_FULL ? skid : in_data;
  end
  // skid register catches the word accepted while the consumer stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) skid <= '0;
    else if (skid_en) skid <= in_data;
  end
endmodule

// File: tb/tb_component_skid_buffer.sv
// tb_component_skid_buffer: directed and scoreboarded checks of the skid buffer
module tb_component_skid_buffer;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready = 1'b0;
  logic [1:0] occupancy;
  int checks = 0;
  int errors = 0;
  logic [7:0] q[$];
  logic m_in_ready;
  logic acc_m, xf_m;

  component_skid_buffer #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    in_valid = 1'b1;
    in_data  = d;
    step();
  endtask

  initial begin
    repeat (2) step();
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_occ", 32'(occupancy), 0);
    rst_n = 1'b1;
    #1;
    chk("rel_in_ready_pre", 32'(in_ready), 0);
    step();
    chk("rel_in_ready", 32'(in_ready), 1);
    chk("rel_out_valid", 32'(out_valid), 0);

    out_ready = 1'b1;
    push(8'hA5);
    chk("single_valid", 32'(out_valid), 1);
    chk("single_data", 32'(out_data), 'hA5);
    chk("single_occ", 32'(occupancy), 1);
    in_valid = 1'b0;
    step();
    chk("single_empty_valid", 32'(out_valid), 0);
    chk("single_empty_occ", 32'(occupancy), 0);

    for (int i = 0; i < 256; i++) begin
      chk("stream_in_ready", 32'(in_ready), 1);
      push(8'(i));
      chk("stream_valid", 32'(out_valid), 1);
      chk("stream_data", 32'(out_data), i);
    end
    in_valid = 1'b0;
    step();
    chk("stream_drain", 32'(out_valid), 0);

    out_ready = 1'b0;
    push(8'h11);
    chk("skid_busy_occ", 32'(occupancy), 1);
    chk("skid_busy_in_ready", 32'(in_ready), 1);
    push(8'h22);
    chk("skid_full_occ", 32'(occupancy), 2);
    chk("skid_full_in_ready", 32'(in_ready), 0);
    chk("skid_full_data", 32'(out_data), 'h11);
    push(8'h33);
    chk("skid_hold_occ", 32'(occupancy), 2);
    chk("skid_hold_in_ready", 32'(in_ready), 0);
    chk("skid_hold_data", 32'(out_data), 'h11);
    step();
    chk("skid_hold2_data", 32'(out_data), 'h11);
    chk("skid_hold2_valid", 32'(out_valid), 1);
    out_ready = 1'b1;
    #1;
    chk("skid_out0", 32'(out_data), 'h11);
    step();
    chk("skid_out1", 32'(out_data), 'h22);
    chk("skid_out1_occ", 32'(occupancy), 1);
    chk("skid_out1_in_ready", 32'(in_ready), 1);
    step();
    chk("skid_out2", 32'(out_data), 'h33);
    chk("skid_out2_occ", 32'(occupancy), 1);
    in_valid = 1'b0;
    step();
    chk("skid_done_occ", 32'(occupancy), 0);

    out_ready = 1'b0;
    push(8'h44);
    push(8'h55);
    chk("mid_full_occ", 32'(occupancy), 2);
    in_valid = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 0);
    chk("mid_rst_in_ready", 32'(in_ready), 0);
    chk("mid_rst_occ", 32'(occupancy), 0);
    chk("mid_rst_data", 32'(out_data), 0);
    step();
    rst_n = 1'b1;
    #1;
    chk("mid_rel_in_ready_pre", 32'(in_ready), 0);
    step();
    chk("mid_rel_in_ready", 32'(in_ready), 1);
    chk("mid_rel_valid", 32'(out_valid), 0);
    chk("mid_rel_occ", 32'(occupancy), 0);

    m_in_ready = 1'b1;
    for (int c = 0; c < 10000; c++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = 8'($urandom);
      out_ready = 1'($urandom_range(0, 1));
      acc_m = in_valid && m_in_ready;
      xf_m  = q.size() != 0 && out_ready;
      step();
      if (xf_m) void'(q.pop_front());
      if (acc_m) q.push_back(in_data);
      m_in_ready = q.size() != 2;
      chk("rnd_occ", 32'(occupancy), q.size());
      chk("rnd_in_ready", 32'(in_ready), 32'(m_in_ready));
      chk("rnd_valid", 32'(out_valid), 32'(q.size() != 0));
      if (q.size() != 0) chk("rnd_data", 32'(out_data), 32'(q[0]));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/component_skid_buffer.md
# component_skid_buffer

Registered valid/ready pipeline stage (two-entry skid buffer) that carries a WIDTH-bit payload from a producer to a consumer with full throughput and backpressure. It closes timing on the consumer's `out_ready` path, because `in_ready` is driven from a flop rather than combinationally from `out_ready`. It sits between any two handshaking blocks in the datapath and is the backpressure-aware counterpart of the team's plain enabled data flop.

## Interface
- `WIDTH`, default 8: payload width in bits.
- `clk`  input  1  rising-edge clock.
- `rst_n`  input  1  asynchronous active-low reset.
- `in_valid`  input  1  producer has a word on `in_data`.
- `in_data`  input  WIDTH  producer payload.
- `in_ready`  output  1  buffer can accept this cycle. Registered.
- `out_valid`  output  1  `out_data` holds a valid word.
- `out_data`  output  WIDTH  payload to consumer. Registered.
- `out_ready`  input  1  consumer accepts this cycle.
- `occupancy`  output  2  number of words held (0–2), for debug and assertions.

## Operation
- Accept on input: `in_valid && in_ready`. Transfer on output: `out_valid && out_ready`.
- Storage is two registers: main (drives `out_data`) and skid.
- States:
  - EMPTY: occ 0.
  - BUSY: occ 1, word in main.
  - FULL: occ 2, main and skid both loaded.
- Transitions from EMPTY:
  - accept → BUSY, main <= `in_data`.
  - otherwise stay.
- Transitions from BUSY:
  - accept and transfer → BUSY, main <= `in_data`.
  - accept only → FULL, skid <= `in_data`.
  - transfer only → EMPTY.
  - neither → stay.
- Transitions from FULL:
  - transfer → BUSY, main <= skid.
  - otherwise stay. No accept is possible in FULL because `in_ready` is 0.
- Decoded outputs:
  - `out_valid` = (state != EMPTY).
  - `in_ready` register is loaded each cycle with (next_state != FULL).
  - `occupancy` is decoded from state.
- Ordering: strict FIFO; no word is dropped or duplicated.
- `in_valid` while `in_ready` = 0 is ignored. `in_data` is don't-care when not accepted.
- AXI-style output rule: once `out_valid` rises, it and `out_data` hold stable until a transfer.
- Reset, asserted at any time including mid-transfer:
  - state EMPTY.
  - main and skid <= 0.
  - `out_valid` = 0, `in_ready` = 0, `occupancy` = 0.
  - All held words are discarded.
- After reset release: `in_ready` rises on the first rising clk edge. Inputs presented before then are not accepted.

## Timing
- Latency: a word accepted at edge N appears on `out_data` with `out_valid` = 1 immediately after edge N, so it is transferable in the cycle following N.
- Throughput: one word per cycle sustained while `out_ready` = 1.
- Backpressure: `out_ready` low for one cycle while BUSY and accepting → `in_ready` low from the next cycle until a transfer occurs.
- No combinational paths between input and output ports: `out_ready` → `in_ready` and `in_valid` → `out_valid` both pass through flops.
- Skid → main move and a new accept never coincide, because FULL blocks input.

## Structure
- Shared package `component_pkg`: state encoding constants `SKB_EMPTY` = 2'd0, `SKB_BUSY` = 2'd1, `SKB_FULL` = 2'd2.
- Single module, no sub-modules.
- Main and skid registers are local async-reset enabled registers. Their enables are decoded from the FSM.
- Unused state encoding 2'd3 maps to EMPTY in the next-state logic.

## Test plan
- Reset then idle: `rst_n` low mid-stream with occ 2 → all outputs 0 immediately. After release: `in_ready` = 1 after the first edge, `out_valid` = 0.
- Single word: push 0xA5 with `out_ready` = 1 → `out_valid` = 1 for one cycle with `out_data` = 0xA5, then EMPTY.
- Streaming: push 0x00..0xFF back-to-back with `out_ready` = 1 → 256 outputs in order, `in_ready` never drops, one word per cycle.
- Skid fill:
  - Stimulus: push 0x11 then 0x22; hold `out_ready` = 0; keep `in_valid` high with 0x33.
  - Response: occ = 2, `in_ready` = 0, 0x33 not accepted, `out_data` = 0x11 stable.
  - Then raise `out_ready` → output sequence 0x11, 0x22, 0x33.
- Random backpressure: random `in_valid` / `out_ready` (50%) for 10k cycles against a scoreboard → exact order, no loss; `out_data` stable while stalled; occupancy always equals accepted minus transferred.
